// File: rtl/uart_pkg.sv
// Shared encodings for the extended UART: parity modes and the RX/TX frame state types.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxParity,
    RxStop
  } rx_state_e;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
    TxParity,
    TxStop
  } tx_state_e;

  // Mode 3 is reserved and behaves like no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every div+1 clocks, realigned by restart.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  assign tick = (cnt_q == '0) && !restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == '0)) begin
      cnt_q <= div;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/uart_ext.sv
// Configurable UART: 5-9 data bits, optional parity, 1/2 stop bits, oversampled
// majority-vote receiver with overrun/framing/parity/break reporting.
module uart_ext #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STRETCH_W  = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_break,
  output logic                 is_receiving,
  output logic                 is_transmitting
);
  import uart_pkg::*;

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0]  MidLo   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  MidCtr  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  MidHi   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OsLast  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BitLast = BIT_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic                 rx_meta_q, rxs, rxs_prev_q;
  rx_state_e            rx_state_q;
  logic [OS_W-1:0]      rx_os_q;
  logic [BIT_W-1:0]     rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_s0_q, rx_s1_q, rx_pbit_q;
  logic [1:0]           rx_par_q;
  logic [DIV_W-1:0]     rx_div_q;
  logic                 rx_wait_q;
  logic                 rx_valid_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_ferr_q, rx_perr_q, rx_ovr_q, rx_brk_q;
  logic [STRETCH_W-1:0] rx_stretch_q;

  logic             rx_tick, rx_restart, rx_pop, rx_maj, rx_par_on, rx_par_calc;
  logic [DIV_W-1:0] rx_div;

  assign rx_restart  = (rx_state_q == RxIdle) && rxs_prev_q && !rxs;
  assign rx_div      = rx_restart ? baud_div : rx_div_q;
  assign rx_pop      = rx_valid_q && rx_ready;
  assign rx_maj      = (rx_s0_q & rx_s1_q) | (rx_s0_q & rxs) | (rx_s1_q & rxs);
  assign rx_par_on   = parity_on(rx_par_q);
  assign rx_par_calc = (^rx_shift_q) ^ (rx_par_q == PAR_ODD);

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_rx_tick (
    .clk     (clk),
    .rst     (rst),
    .div     (rx_div),
    .restart (rx_restart),
    .tick    (rx_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rxs          <= 1'b1;
      rxs_prev_q   <= 1'b1;
      rx_state_q   <= RxIdle;
      rx_os_q      <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_s0_q      <= 1'b1;
      rx_s1_q      <= 1'b1;
      rx_pbit_q    <= 1'b0;
      rx_par_q     <= PAR_NONE;
      rx_div_q     <= '0;
      rx_wait_q    <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_ferr_q    <= 1'b0;
      rx_perr_q    <= 1'b0;
      rx_ovr_q     <= 1'b0;
      rx_brk_q     <= 1'b0;
      rx_stretch_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rxs        <= rx_meta_q;
      rxs_prev_q <= rxs;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_brk_q   <= 1'b0;
      if (rx_pop) rx_valid_q <= 1'b0;
      if (rx_stretch_q != '0) rx_stretch_q <= rx_stretch_q - 1'b1;

      if (rx_state_q == RxIdle) begin
        if (rx_restart) begin
          rx_state_q <= RxStart;
          rx_os_q    <= '0;
          rx_par_q   <= parity_mode;
          rx_div_q   <= baud_div;
        end
      end else if (rx_wait_q) begin
        // Bad stop bit: hold off until the line is released.
        if (rxs) begin
          rx_wait_q  <= 1'b0;
          rx_state_q <= RxIdle;
        end
      end else if (rx_tick) begin
        rx_os_q <= (rx_os_q == OsLast) ? '0 : rx_os_q + 1'b1;
        if (rx_os_q == MidLo)  rx_s0_q <= rxs;
        if (rx_os_q == MidCtr) rx_s1_q <= rxs;

        unique case (rx_state_q)
          RxStart: begin
            if (rx_os_q == MidHi) begin
              if (rx_maj) rx_state_q <= RxIdle;
              else        rx_stretch_q <= '1;
            end
            if (rx_os_q == OsLast) begin
              rx_state_q <= RxData;
              rx_bit_q   <= '0;
            end
          end
          RxData: begin
            if (rx_os_q == MidHi) rx_shift_q <= {rx_maj, rx_shift_q[DATA_BITS-1:1]};
            if (rx_os_q == OsLast) begin
              if (rx_bit_q == BitLast) rx_state_q <= rx_par_on ? RxParity : RxStop;
              else                     rx_bit_q   <= rx_bit_q + 1'b1;
            end
          end
          RxParity: begin
            if (rx_os_q == MidHi)  rx_pbit_q  <= rx_maj;
            if (rx_os_q == OsLast) rx_state_q <= RxStop;
          end
          RxStop: begin
            if (rx_os_q == MidHi) begin
              if (rx_maj) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
                rx_ovr_q   <= rx_valid_q && !rx_pop;
                rx_perr_q  <= rx_par_on && (rx_pbit_q != rx_par_calc);
                rx_state_q <= RxIdle;
              end else begin
                if ((rx_shift_q == '0) && !(rx_par_on && rx_pbit_q)) rx_brk_q  <= 1'b1;
                else                                                 rx_ferr_q <= 1'b1;
                rx_wait_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_valid      = rx_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_break      = rx_brk_q;
  assign is_receiving  = (rx_stretch_q != '0);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e            tx_state_q;
  logic [OS_W-1:0]      tx_os_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q, tx_data_q;
  logic [1:0]           tx_par_q;
  logic                 tx_stop2_q, tx_stop_cnt_q;
  logic [DIV_W-1:0]     tx_div_q;
  logic                 tx_q, tx_ready_q;
  logic [STRETCH_W-1:0] tx_stretch_q;

  logic             tx_tick, tx_restart;
  logic [DIV_W-1:0] tx_div;

  assign tx_restart = (tx_state_q == TxIdle) && tx_valid;
  assign tx_div     = tx_restart ? baud_div : tx_div_q;

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_tx_tick (
    .clk     (clk),
    .rst     (rst),
    .div     (tx_div),
    .restart (tx_restart),
    .tick    (tx_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q    <= TxIdle;
      tx_os_q       <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_data_q     <= '0;
      tx_par_q      <= PAR_NONE;
      tx_stop2_q    <= 1'b0;
      tx_stop_cnt_q <= 1'b0;
      tx_div_q      <= '0;
      tx_q          <= 1'b1;
      tx_ready_q    <= 1'b1;
      tx_stretch_q  <= '0;
    end else begin
      if (tx_stretch_q != '0) tx_stretch_q <= tx_stretch_q - 1'b1;

      if (tx_state_q == TxIdle) begin
        if (tx_valid) begin
          tx_shift_q   <= tx_data;
          tx_data_q    <= tx_data;
          tx_par_q     <= parity_mode;
          tx_stop2_q   <= stop2;
          tx_div_q     <= baud_div;
          tx_q         <= 1'b0;
          tx_ready_q   <= 1'b0;
          tx_os_q      <= '0;
          tx_state_q   <= TxStart;
          tx_stretch_q <= '1;
        end
      end else if (tx_tick) begin
        tx_os_q <= (tx_os_q == OsLast) ? '0 : tx_os_q + 1'b1;
        if (tx_os_q == OsLast) begin
          unique case (tx_state_q)
            TxStart: begin
              tx_q       <= tx_shift_q[0];
              tx_bit_q   <= '0;
              tx_state_q <= TxData;
            end
            TxData: begin
              if (tx_bit_q == BitLast) begin
                if (parity_on(tx_par_q)) begin
                  tx_q       <= (^tx_data_q) ^ (tx_par_q == PAR_ODD);
                  tx_state_q <= TxParity;
                end else begin
                  tx_q          <= 1'b1;
                  tx_stop_cnt_q <= 1'b0;
                  tx_state_q    <= TxStop;
                end
              end else begin
                tx_shift_q <= tx_shift_q >> 1;
                tx_q       <= tx_shift_q[1];
                tx_bit_q   <= tx_bit_q + 1'b1;
              end
            end
            TxParity: begin
              tx_q          <= 1'b1;
              tx_stop_cnt_q <= 1'b0;
              tx_state_q    <= TxStop;
            end
            TxStop: begin
              if (tx_stop2_q && !tx_stop_cnt_q) begin
                tx_stop_cnt_q <= 1'b1;
              end else begin
                tx_ready_q <= 1'b1;
                tx_state_q <= TxIdle;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign tx              = tx_q;
  assign tx_ready        = tx_ready_q;
  assign is_transmitting = (tx_stretch_q != '0);

endmodule

// File: tb/tb_uart_ext.sv
// Randomised bench for uart_ext: frames are modelled as bit lists built from the
// data, parity and stop settings, then compared with the line or the receiver.
module tb_uart_ext;

  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  parity_mode;
  logic        stop2;
  logic        rx, tx;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data, rx_data;
  logic        rx_valid, rx_ready;
  logic        rx_frame_err, rx_parity_err, rx_overrun, rx_break;
  logic        is_receiving, is_transmitting;

  logic loop_en, rx_line;
  assign rx = loop_en ? tx : rx_line;

  always #5 clk = ~clk;

  uart_ext #(
    .DATA_BITS (8),
    .DIV_W     (16),
    .OVERSAMPLE(OS),
    .STRETCH_W (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_div       (baud_div),
    .parity_mode    (parity_mode),
    .stop2          (stop2),
    .rx             (rx),
    .tx             (tx),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .rx_frame_err   (rx_frame_err),
    .rx_parity_err  (rx_parity_err),
    .rx_overrun     (rx_overrun),
    .rx_break       (rx_break),
    .is_receiving   (is_receiving),
    .is_transmitting(is_transmitting)
  );

  int n_checks = 0;
  int n_errors = 0;
  int bit_clks;
  int n_ferr = 0, n_perr = 0, n_ovr = 0, n_brk = 0;
  int f0, p0, o0, b0;

  always @(negedge clk) begin
    if (rx_frame_err)  n_ferr++;
    if (rx_parity_err) n_perr++;
    if (rx_overrun)    n_ovr++;
    if (rx_break)      n_brk++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s). Unused bits are 1.
  function automatic int build_frame(input logic [7:0] d, input logic [1:0] mode,
                                     input logic s2, output logic [15:0] bits);
    int n;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (mode == 2'd1 || mode == 2'd2) begin
      // Even: total ones even; odd: total ones odd.
      bits[n] = (^d) ^ (mode == 2'd2);
      n++;
    end
    n = n + (s2 ? 2 : 1);
    return n;
  endfunction

  task automatic set_cfg(input int div, input logic [1:0] mode, input logic s2);
    baud_div    = 16'(div);
    parity_mode = mode;
    stop2       = s2;
    bit_clks    = OS * (div + 1);
  endtask

  task automatic snap();
    f0 = n_ferr; p0 = n_perr; o0 = n_ovr; b0 = n_brk;
  endtask

  task automatic check_errs(input string tag, input int ef, input int ep, input int eo,
                            input int eb);
    check({tag, "_ferr"}, n_ferr - f0, ef);
    check({tag, "_perr"}, n_perr - p0, ep);
    check({tag, "_ovr"},  n_ovr - o0,  eo);
    check({tag, "_brk"},  n_brk - b0,  eb);
  endtask

  task automatic pop(input string tag);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    check({tag, "_pop"}, rx_valid, 0);
  endtask

  task automatic drive_frame(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) rx_line = bits[i];
      repeat (bit_clks - 1) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int k);
    @(negedge clk) rx_line = 1'b1;
    repeat (k * bit_clks - 1) @(negedge clk);
  endtask

  // Sends one byte in loopback, samples every bit mid-period and checks the receiver.
  task automatic tx_frame(input logic [7:0] d, input logic [1:0] mode, input logic s2,
                          input int div, input bit scramble);
    logic [15:0] exp_bits, got_bits;
    int n, skip;
    set_cfg(div, mode, s2);
    n = build_frame(d, mode, s2, exp_bits);
    snap();
    got_bits = '1;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    check("tx_ready_drop", tx_ready, 0);
    check("is_tx", is_transmitting, 1);
    repeat (bit_clks / 2) @(posedge clk);
    #1 got_bits[0] = tx;
    skip = 0;
    if (scramble) begin
      // Config changes and a second request mid-frame must not disturb this frame.
      baud_div    = 16'($urandom_range(0, 3));
      parity_mode = 2'($urandom_range(0, 3));
      stop2       = 1'($urandom_range(0, 1));
      tx_valid    = 1'b1;
      tx_data     = ~d;
      @(posedge clk); #1 tx_valid = 1'b0;
      skip = 1;
    end
    for (int k = 1; k < n; k++) begin
      repeat (bit_clks - skip) @(posedge clk);
      #1 got_bits[k] = tx;
      skip = 0;
    end
    check("tx_line", got_bits, exp_bits);
    repeat (bit_clks / 2 - 1) @(posedge clk);
    #1 check("tx_busy_end", tx_ready, 0);
    @(posedge clk);
    #1 check("tx_ready_rise", tx_ready, 1);
    check("lb_valid", rx_valid, 1);
    check("lb_data", rx_data, d);
    check_errs("lb", 0, 0, 0, 0);
    pop("lb");
  endtask

  initial begin
    logic [15:0] bits;
    logic [7:0]  d, flip;
    int          n;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    loop_en = 1'b1; rx_line = 1'b1;
    set_cfg(2, 2'd0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_pulses", {rx_frame_err, rx_parity_err, rx_overrun, rx_break}, 0);
    check("rst_activity", {is_receiving, is_transmitting}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);

    // Loopback: directed, then randomised with mid-frame disturbances.
    tx_frame(8'hA5, 2'd0, 1'b0, 2, 1'b0);
    tx_frame(8'h07, 2'd1, 1'b0, 2, 1'b0);
    for (int i = 0; i < 6; i++)
      tx_frame(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), 1'b1);

    // Bench-driven receiver tests.
    loop_en = 1'b0;
    rx_line = 1'b1;

    for (int i = 0; i < 4; i++) begin
      set_cfg($urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'b0);
      d = 8'($urandom);
      n = build_frame(d, parity_mode, 1'b0, bits);
      snap();
      drive_frame(bits, n);
      idle_bits(1);
      check("rx_rand_valid", rx_valid, 1);
      check("rx_rand_data", rx_data, d);
      check_errs("rx_rand", 0, 0, 0, 0);
      pop("rx_rand");
    end

    // Parity error: one data bit flipped on the line, byte still delivered.
    set_cfg(1, 2'd1, 1'b0);
    d    = 8'($urandom);
    flip = 8'(1 << $urandom_range(0, 7));
    n    = build_frame(d, 2'd1, 1'b0, bits);
    bits[8:1] = bits[8:1] ^ flip;
    snap();
    drive_frame(bits, n);
    idle_bits(1);
    check("par_valid", rx_valid, 1);
    check("par_data", rx_data, d ^ flip);
    check_errs("par", 0, 1, 0, 0);
    pop("par");

    // Framing error: stop bit low on 0x55.
    set_cfg(2, 2'd0, 1'b0);
    n = build_frame(8'h55, 2'd0, 1'b0, bits);
    bits[9] = 1'b0;
    snap();
    drive_frame(bits, n);
    idle_bits(2);
    check("ferr_valid", rx_valid, 0);
    check_errs("ferr", 1, 0, 0, 0);

    // Break: line low for two frame times gives a single pulse, then recovery.
    snap();
    @(negedge clk) rx_line = 1'b0;
    repeat (20 * bit_clks) @(negedge clk);
    idle_bits(2);
    check("brk_valid", rx_valid, 0);
    check_errs("brk", 0, 0, 0, 1);
    n = build_frame(8'h5A, 2'd0, 1'b0, bits);
    drive_frame(bits, n);
    idle_bits(1);
    check("brk_recover", rx_data, 8'h5A);
    pop("brk");

    // Overrun: two frames without a pop; newest data kept.
    snap();
    n = build_frame(8'h11, 2'd0, 1'b0, bits);
    drive_frame(bits, n);
    idle_bits(1);
    n = build_frame(8'h22, 2'd0, 1'b0, bits);
    drive_frame(bits, n);
    idle_bits(1);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h22);
    check_errs("ovr", 0, 0, 1, 0);
    pop("ovr");

    // One-tick glitch while idle is rejected silently.
    repeat (300) @(negedge clk);
    check("glitch_pre", is_receiving, 0);
    snap();
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(2);
    check("glitch_valid", rx_valid, 0);
    check("glitch_active", is_receiving, 0);
    check_errs("glitch", 0, 0, 0, 0);

    // Reset mid-frame in loopback, then a clean frame.
    loop_en = 1'b1;
    set_cfg(1, 2'd0, 1'b0);
    snap();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'h96;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (4 * bit_clks + bit_clks / 2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_valid", rx_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * bit_clks) @(posedge clk);
    check("post_rst_valid", rx_valid, 0);
    check_errs("mid_rst", 0, 0, 0, 0);
    tx_frame(8'h3C, 2'd0, 1'b0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
